cnn_state_update: RTL and testbench

//  Downstream stage of the CNN cell equation datapath (A*Y + B*U + I sum, 17-bit signed).

---
 rtl/cnn_pkg.sv | 32 +++
 rtl/cnn_state_update_if.sv | 28 ++
 rtl/cnn_pwl_sat.sv | 30 +++
 rtl/cnn_state_update.sv | 154 +++++++++++++++
 tb/tb_cnn_state_update.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared widths, FSM encoding and saturate/clamp helpers for the CNN state update stage
package cnn_pkg;

    localparam int EQ_W = 17;
    localparam int Y_W  = 9;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN
    } state_t;

    // Saturate a signed value to the range of a w-bit two's complement number.
    function automatic logic signed [31:0] sat_w(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Piecewise-linear cell output: clamp to [-yone, +yone].
    function automatic logic signed [31:0] clamp_y(input logic signed [31:0] v, input int yone);
        if (v > yone) return yone;
        if (v < -yone) return -yone;
        return v;
    endfunction

endpackage

// File: rtl/cnn_state_update_if.sv
// rtl/cnn_state_update_if.sv - eq sample input stream and y output stream of the state update stage
// Ports (signals): in_valid/in_ready/in_addr/in_eq carry equation samples into the stage,
// out_valid/out_ready/out_addr/out_y carry clamped cell outputs out of it.
// master = producer/consumer side, slave = the state update stage.
interface cnn_state_update_if #(
    parameter int AW = 6
) ();
    import cnn_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [AW-1:0]           in_addr;
    logic signed [EQ_W-1:0]  in_eq;
    logic                    out_valid;
    logic                    out_ready;
    logic [AW-1:0]           out_addr;
    logic signed [Y_W-1:0]   out_y;

    modport master (
        output in_valid, in_addr, in_eq, out_ready,
        input  in_ready, out_valid, out_addr, out_y
    );

    modport slave (
        input  in_valid, in_addr, in_eq, out_ready,
        output in_ready, out_valid, out_addr, out_y
    );
endinterface

// File: rtl/cnn_pwl_sat.sv
// rtl/cnn_pwl_sat.sv - combinational forward-Euler state step with XW saturation and YONE output clamp
// Ports: eq (signed equation value), x_old (current state) in;
//        x_new (saturated next state), y (clamped 9-bit cell output) out.
module cnn_pwl_sat
    import cnn_pkg::*;
#(
    parameter int XW       = 18,
    parameter int DT_SHIFT = 3,
    parameter int YONE     = 128
) (
    input  logic signed [EQ_W-1:0] eq,
    input  logic signed [XW-1:0]   x_old,
    output logic signed [XW-1:0]   x_new,
    output logic signed [Y_W-1:0]  y
);

    logic signed [XW:0] diff;
    logic signed [XW:0] step;
    logic signed [31:0] sum;

    always_comb begin
        diff  = (XW+1)'(eq) - (XW+1)'(x_old);
        // Arithmetic shift floors toward -inf, so small negative steps never round to zero.
        step  = diff >>> DT_SHIFT;
        sum   = 32'(x_old) + 32'(step);
        x_new = XW'(sat_w(sum, XW));
        y     = Y_W'(clamp_y(32'(x_new), YONE));
    end

endmodule

// File: rtl/cnn_state_update.sv
// rtl/cnn_state_update.sv - per-cell state integrator: state RAM, clear, 2-stage update pipeline, iteration control
// Ports: clk, rst (async active-high); start/n_iter begin a run of n_iter iterations;
//        bus (slave) carries eq samples in and y results out; busy high outside IDLE;
//        iter_cnt counts completed iterations; done pulses one cycle at run end.
module cnn_state_update
    import cnn_pkg::*;
#(
    parameter int NCELL    = 64,
    parameter int AW       = 6,
    parameter int XW       = 18,
    parameter int DT_SHIFT = 3,
    parameter int YONE     = 128,
    parameter int ITW      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ITW-1:0]       n_iter,
    cnn_state_update_if.slave    bus,
    output logic                 busy,
    output logic [ITW-1:0]       iter_cnt,
    output logic                 done
);

    state_t state, state_nx;

    logic [AW-1:0]          clr_cnt;
    logic [AW-1:0]          upd_cnt;
    logic [ITW-1:0]         n_iter_q;

    logic                   s1_valid;
    logic [AW-1:0]          s1_addr;
    logic signed [EQ_W-1:0] s1_eq;
    logic                   fwd_sel;
    logic signed [XW-1:0]   fwd_x;
    logic signed [XW-1:0]   ram_q;
    logic signed [XW-1:0]   x_old;
    logic signed [XW-1:0]   x_new;
    logic signed [Y_W-1:0]  y_new;

    logic signed [XW-1:0]   ram [NCELL];
    logic                   ram_we;
    logic [AW-1:0]          ram_wa;
    logic signed [XW-1:0]   ram_wd;

    logic adv, accept, s1_fire, last_clr, last_upd, iter_end;

    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = (state == RUN) && adv;
    assign accept       = bus.in_valid && bus.in_ready;
    assign s1_fire      = s1_valid && adv;
    assign last_clr     = (clr_cnt == AW'(NCELL - 1));
    assign last_upd     = (upd_cnt == AW'(NCELL - 1));
    assign iter_end     = accept && last_upd && ((iter_cnt + ITW'(1)) == n_iter_q);
    assign busy         = (state != IDLE);

    always_comb begin
        state_nx = state;
        done     = 1'b0;
        case (state)
            IDLE:  if (start) state_nx = CLEAR;
            CLEAR: if (last_clr) state_nx = (n_iter_q == '0) ? DRAIN : RUN;
            RUN:   if (iter_end) state_nx = DRAIN;
            DRAIN: begin
                if (!s1_valid && !bus.out_valid) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            clr_cnt  <= '0;
            upd_cnt  <= '0;
            iter_cnt <= '0;
            n_iter_q <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                n_iter_q <= n_iter;
                iter_cnt <= '0;
                clr_cnt  <= '0;
                upd_cnt  <= '0;
            end
            if (state == CLEAR) clr_cnt <= clr_cnt + AW'(1);
            // Iterations are defined by accept count only; addresses may arrive in any order.
            if (accept) begin
                if (last_upd) begin
                    upd_cnt  <= '0;
                    iter_cnt <= iter_cnt + ITW'(1);
                end else begin
                    upd_cnt <= upd_cnt + AW'(1);
                end
            end
        end
    end

    // The RAM read lands one cycle after accept; if S1 was writing the same cell on that
    // accept edge, the RAM still returns the old value, so the fresh x_new is captured instead.
    assign x_old = fwd_sel ? fwd_x : ram_q;

    cnn_pwl_sat #(
        .XW       (XW),
        .DT_SHIFT (DT_SHIFT),
        .YONE     (YONE)
    ) u_pwl (
        .eq    (s1_eq),
        .x_old (x_old),
        .x_new (x_new),
        .y     (y_new)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_addr       <= '0;
            s1_eq         <= '0;
            fwd_sel       <= 1'b0;
            fwd_x         <= '0;
            bus.out_valid <= 1'b0;
            bus.out_addr  <= '0;
            bus.out_y     <= '0;
        end else begin
            if (accept) begin
                s1_eq   <= bus.in_eq;
                s1_addr <= bus.in_addr;
                fwd_sel <= s1_fire && (s1_addr == bus.in_addr);
                fwd_x   <= x_new;
            end
            if (adv) begin
                s1_valid      <= accept;
                bus.out_valid <= s1_valid;
                if (s1_valid) begin
                    bus.out_addr <= s1_addr;
                    bus.out_y    <= y_new;
                end
            end
        end
    end

    assign ram_we = (state == CLEAR) || s1_fire;
    assign ram_wa = (state == CLEAR) ? clr_cnt : s1_addr;
    assign ram_wd = (state == CLEAR) ? '0 : x_new;

    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_wa] <= ram_wd;
        if (accept) ram_q <= ram[bus.in_addr];
    end

endmodule

// File: tb/tb_cnn_state_update.sv
// tb/tb_cnn_state_update.sv - scoreboard bench for cnn_state_update with NCELL=4, DT_SHIFT=3, YONE=128
module tb_cnn_state_update;
    import cnn_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] n_iter;
    logic       busy;
    logic       done;
    logic [7:0] iter_cnt;

    cnn_state_update_if #(.AW(2)) bus ();

    cnn_state_update #(
        .NCELL(4), .AW(2), .XW(18), .DT_SHIFT(3), .YONE(128), .ITW(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .n_iter   (n_iter),
        .bus      (bus),
        .busy     (busy),
        .iter_cnt (iter_cnt),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int y;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Output monitor: pops the expected queue on every output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got addr %0d y %0d expected no output",
                             bus.out_addr, bus.out_y);
                end else begin
                    e = sb.pop_front();
                    chk("out_addr", {30'd0, bus.out_addr}, e.addr);
                    chk("out_y", bus.out_y, e.y);
                end
            end
        end
    end

    task automatic send(input int addr, input int eq, input int y);
        bit got;
        got = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_addr  = addr[1:0];
        bus.in_eq    = eq[16:0];
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (got) sb.push_back('{addr, y});
        else chk("send_timeout", 0, 1);
    endtask

    task automatic run_start(input int n);
        start  = 1'b1;
        n_iter = n[7:0];
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int exp_iter);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        chk("done_seen", {31'd0, seen}, 1);
        chk("iter_cnt", {24'd0, iter_cnt}, exp_iter);
        @(negedge clk);
        chk("done_single", {31'd0, done}, 0);
        chk("busy_after_done", {31'd0, busy}, 0);
        chk("sb_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        n_iter        = '0;
        bus.in_valid  = 1'b0;
        bus.in_addr   = '0;
        bus.in_eq     = '0;
        bus.out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_iter_cnt", {24'd0, iter_cnt}, 0);
        chk("rst_out_y", bus.out_y, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Two passes of eq=800: x 0->100->187, y 100 then clamped 128
        run_start(2);
        for (int a = 0; a < 4; a++) send(a, 800, 100);
        for (int a = 0; a < 4; a++) send(a, 800, 128);
        wait_done(2);

        // n_iter=0: clear then straight to drain
        run_start(0);
        wait_done(0);

        // Fresh run clears state; floor shift and negative clamp
        run_start(1);
        send(0, -9, -2);       // -9>>>3 = -2
        send(1, -4000, -128);  // x=-500
        send(2, 800, 100);
        send(0, -4000, -128);  // x=-2 + floor(-3998/8) = -502
        wait_done(1);

        // Back-to-back same cell (forwarding) under an output stall
        run_start(2);
        bus.out_ready = 1'b0;
        send(0, 800, 100);     // x=100
        send(0, 800, 128);     // x=187, needs forwarded x_old
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, bus.in_ready}, 0);
            chk("stall_out_valid", {31'd0, bus.out_valid}, 1);
            chk("stall_out_addr", {30'd0, bus.out_addr}, 0);
            chk("stall_out_y", bus.out_y, 100);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(1, 800, 100);
        send(2, -9, -2);
        send(0, -9, 128);      // 187 + floor(-196/8) = 162
        send(1, -9, 86);       // 100 + floor(-109/8) = 86
        send(3, -4000, -128);  // -500
        send(2, -9, -3);       // -2 + floor(-7/8) = -3
        wait_done(2);

        // Start ignored in RUN, then reset mid-run with results in flight
        run_start(2);
        send(0, 800, 100);
        send(1, 800, 100);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("start_ignored_busy", {31'd0, busy}, 1);
        chk("start_ignored_in_ready", {31'd0, bus.in_ready}, 1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send(2, 800, 100);
        send(3, 800, 100);
        @(negedge clk);
        chk("pre_rst_out_valid", {31'd0, bus.out_valid}, 1);
        chk("pre_rst_iter_cnt", {24'd0, iter_cnt}, 1);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", {31'd0, bus.out_valid}, 0);
        chk("abort_in_ready", {31'd0, bus.in_ready}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_iter_cnt", {24'd0, iter_cnt}, 0);
        chk("abort_out_y", bus.out_y, 0);
        chk("abort_out_addr", {30'd0, bus.out_addr}, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        run_start(1);
        for (int a = 0; a < 4; a++) send(a, 800, 100);
        wait_done(1);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
